tmr_fault_monitor: RTL and testbench

Sequential supervisor that consumes the 3-bit pairwise agreement vector from the TMR voter and drives fault recovery for the triplicated RISC-V core. It classifies each sampled vector as clean, single-lane fault or no-majority, and filters transient upsets. It escalates a fault that persists on one lane into a resync request for that lane, and escalates a lost majority into a fatal halt.

---
 rtl/tmr_pkg.sv | 47 ++++
 rtl/tmr_vote_decode.sv | 24 ++
 rtl/tmr_fault_monitor.sv | 176 +++++++++++++++++
 tb/tb_tmr_fault_monitor.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tmr_pkg.sv
// tmr_pkg: shared types for the TMR fault monitor.
//   state_t   : supervisor states (normal, suspect, resync, halt)
//   verdict_t : classification of one voter agreement sample
//   LANE_*    : lane identifiers used for diagnosis (0 none, 1 A, 2 B, 3 C)
package tmr_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL,
    ST_SUSPECT,
    ST_RESYNC,
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    VD_OK,
    VD_BAD_A,
    VD_BAD_B,
    VD_BAD_C,
    VD_NOMAJ
  } verdict_t;

  localparam logic [1:0] LANE_NONE = 2'd0;
  localparam logic [1:0] LANE_A    = 2'd1;
  localparam logic [1:0] LANE_B    = 2'd2;
  localparam logic [1:0] LANE_C    = 2'd3;

  // Lane blamed by a verdict; LANE_NONE for OK and NOMAJ.
  function automatic logic [1:0] verdict_lane(verdict_t v);
    case (v)
      VD_BAD_A: return LANE_A;
      VD_BAD_B: return LANE_B;
      VD_BAD_C: return LANE_C;
      default:  return LANE_NONE;
    endcase
  endfunction

  // One-hot lane select: [0]=A, [1]=B, [2]=C.
  function automatic logic [2:0] lane_onehot(logic [1:0] lane);
    case (lane)
      LANE_A:  return 3'b001;
      LANE_B:  return 3'b010;
      LANE_C:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/tmr_vote_decode.sv
// tmr_vote_decode: combinational classifier of the voter agreement vector.
//   voter_state in  3  {AB,BC,AC}, bit high = that pair agrees
//   verdict     out    VD_OK / VD_BAD_x / VD_NOMAJ
// A single agreeing pair blames the lane outside that pair. Two agreeing
// pairs is logically impossible and is treated as lost majority.
module tmr_vote_decode
  import tmr_pkg::*;
(
  input  logic [2:0] voter_state,
  output verdict_t   verdict
);

  always_comb begin
    verdict = VD_NOMAJ;
    case (voter_state)
      3'b111:  verdict = VD_OK;
      3'b010:  verdict = VD_BAD_A;
      3'b001:  verdict = VD_BAD_B;
      3'b100:  verdict = VD_BAD_C;
      default: verdict = VD_NOMAJ;
    endcase
  end

endmodule

// File: rtl/tmr_fault_monitor.sv
// tmr_fault_monitor: fault supervisor for the triplicated core.
// Filters transient single-lane upsets, requests a resync of a lane that
// stays bad for PERSIST_CYCLES valid samples, and halts on lost majority or
// on a resync that is not acknowledged within RESYNC_TIMEOUT cycles.
// Ports:
//   clk, rst_in (sync, active high)
//   Voter_state[2:0], Voter_valid      voter agreement sample
//   Resync_ack, Fault_clear            recovery handshake / halt release
//   Resync_req, Resync_lane[2:0]       resync request, one-hot lane
//   Core_stall, Fatal                  lane freeze, fatal halt
//   Fault_lane[1:0], Resync_cnt[7:0]   last diagnosed lane, completed resyncs
//   Err_cnt_A/B/C[CNT_W-1:0]           per-lane fault-sample counters
// Build option: TMR_MON_STATS_EN enables the per-lane counters; without it
// the Err_cnt ports are constant zero.
module tmr_fault_monitor
  import tmr_pkg::*;
#(
  parameter int unsigned PERSIST_CYCLES = 4,
  parameter int unsigned RESYNC_TIMEOUT = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic [2:0]       Voter_state,
  input  logic             Voter_valid,
  input  logic             Resync_ack,
  input  logic             Fault_clear,
  output logic             Resync_req,
  output logic [2:0]       Resync_lane,
  output logic             Core_stall,
  output logic             Fatal,
  output logic [1:0]       Fault_lane,
  output logic [7:0]       Resync_cnt,
  output logic [CNT_W-1:0] Err_cnt_A,
  output logic [CNT_W-1:0] Err_cnt_B,
  output logic [CNT_W-1:0] Err_cnt_C
);

  localparam logic [7:0]  PERSIST_MAX = 8'(PERSIST_CYCLES);
  localparam logic [15:0] TIMEOUT_MAX = 16'(RESYNC_TIMEOUT);

  state_t      state_q, state_d;
  logic [1:0]  susp_q, susp_d;
  logic [7:0]  persist_q, persist_d;
  logic [15:0] timer_q, timer_d;
  logic [1:0]  fault_lane_q;
  logic [7:0]  resync_cnt_q;
  logic        resync_done;
  logic        lane_bad;
  verdict_t    verdict;
  logic [1:0]  verdict_l;

  tmr_vote_decode u_decode (
    .voter_state (Voter_state),
    .verdict     (verdict)
  );

  assign verdict_l = verdict_lane(verdict);
  assign lane_bad  = Voter_valid && (verdict_l != LANE_NONE) &&
                     (state_q == ST_NORMAL || state_q == ST_SUSPECT);

  always_comb begin
    state_d     = state_q;
    susp_d      = susp_q;
    persist_d   = persist_q;
    timer_d     = timer_q;
    resync_done = 1'b0;
    Resync_req  = 1'b0;
    Resync_lane = '0;
    Core_stall  = 1'b0;
    Fatal       = 1'b0;

    case (state_q)
      // NORMAL and SUSPECT share one decision: a bad sample from NORMAL
      // always starts a fresh streak, from SUSPECT it extends a matching one.
      ST_NORMAL, ST_SUSPECT: begin
        if (Voter_valid) begin
          case (verdict)
            VD_OK: begin
              state_d   = ST_NORMAL;
              persist_d = '0;
            end
            VD_NOMAJ: state_d = ST_HALT;
            default: begin
              if (state_q == ST_SUSPECT && verdict_l == susp_q)
                persist_d = (persist_q >= PERSIST_MAX) ? PERSIST_MAX : persist_q + 8'd1;
              else
                persist_d = 8'd1;
              susp_d  = verdict_l;
              timer_d = '0;
              state_d = (persist_d >= PERSIST_MAX) ? ST_RESYNC : ST_SUSPECT;
            end
          endcase
        end
      end
      ST_RESYNC: begin
        Resync_req  = 1'b1;
        Resync_lane = lane_onehot(susp_q);
        Core_stall  = 1'b1;
        // Ack is checked first so it wins over a simultaneous timeout.
        if (Resync_ack) begin
          state_d     = ST_NORMAL;
          resync_done = 1'b1;
          persist_d   = '0;
          timer_d     = '0;
        end else if (timer_q + 16'd1 >= TIMEOUT_MAX) begin
          state_d = ST_HALT;
          timer_d = TIMEOUT_MAX;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      ST_HALT: begin
        Core_stall = 1'b1;
        Fatal      = 1'b1;
        if (Fault_clear) begin
          state_d   = ST_NORMAL;
          persist_d = '0;
          timer_d   = '0;
        end
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q      <= ST_NORMAL;
      susp_q       <= LANE_NONE;
      persist_q    <= '0;
      timer_q      <= '0;
      fault_lane_q <= LANE_NONE;
      resync_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      susp_q    <= susp_d;
      persist_q <= persist_d;
      timer_q   <= timer_d;
      if (lane_bad)
        fault_lane_q <= verdict_l;
      if (resync_done && resync_cnt_q != 8'hFF)
        resync_cnt_q <= resync_cnt_q + 8'd1;
    end
  end

  assign Fault_lane = fault_lane_q;
  assign Resync_cnt = resync_cnt_q;

`ifdef TMR_MON_STATS_EN
  logic [CNT_W-1:0] err_a_q, err_b_q, err_c_q;

  always_ff @(posedge clk) begin
    if (rst_in) begin
      err_a_q <= '0;
      err_b_q <= '0;
      err_c_q <= '0;
    end else if (lane_bad) begin
      case (verdict_l)
        LANE_A:  if (err_a_q != '1) err_a_q <= err_a_q + CNT_W'(1);
        LANE_B:  if (err_b_q != '1) err_b_q <= err_b_q + CNT_W'(1);
        LANE_C:  if (err_c_q != '1) err_c_q <= err_c_q + CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign Err_cnt_A = err_a_q;
  assign Err_cnt_B = err_b_q;
  assign Err_cnt_C = err_c_q;
`else
  assign Err_cnt_A = '0;
  assign Err_cnt_B = '0;
  assign Err_cnt_C = '0;
`endif

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// tb_tmr_fault_monitor: directed vector table, hand-written corner sequences
// and randomized traffic against a behavioural model of the fault monitor.
module tb_tmr_fault_monitor;

  localparam int unsigned P  = 4;
  localparam int unsigned TO = 8;
  localparam int unsigned W  = 16;

  logic         clk = 1'b0;
  logic         rst_in, Voter_valid, Resync_ack, Fault_clear;
  logic [2:0]   Voter_state;
  logic         Resync_req, Core_stall, Fatal;
  logic [2:0]   Resync_lane;
  logic [1:0]   Fault_lane;
  logic [7:0]   Resync_cnt;
  logic [W-1:0] Err_cnt_A, Err_cnt_B, Err_cnt_C;

  always #5 clk = ~clk;

  tmr_fault_monitor #(
    .PERSIST_CYCLES (P),
    .RESYNC_TIMEOUT (TO),
    .CNT_W          (W)
  ) dut (
    .clk         (clk),
    .rst_in      (rst_in),
    .Voter_state (Voter_state),
    .Voter_valid (Voter_valid),
    .Resync_ack  (Resync_ack),
    .Fault_clear (Fault_clear),
    .Resync_req  (Resync_req),
    .Resync_lane (Resync_lane),
    .Core_stall  (Core_stall),
    .Fatal       (Fatal),
    .Fault_lane  (Fault_lane),
    .Resync_cnt  (Resync_cnt),
    .Err_cnt_A   (Err_cnt_A),
    .Err_cnt_B   (Err_cnt_B),
    .Err_cnt_C   (Err_cnt_C)
  );

  int checks   = 0;
  int failures = 0;

`ifdef TMR_MON_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // ---------------- behavioural model ----------------
  bit m_halted, m_in_resync;
  int m_streak, m_streak_lane, m_wait, m_flane, m_rc;
  int m_err[4];

  // 0 = all agree, 1..3 = lane A..C bad, -1 = no majority.
  function automatic int classify(logic [2:0] v);
    if (v == 3'b111) return 0;
    if ($countones(v) == 1) begin
      if (v[2]) return 3;  // only A,B agree
      if (v[1]) return 1;  // only B,C agree
      return 2;            // only A,C agree
    end
    return -1;
  endfunction

  task automatic model_step(bit r, logic [2:0] vs, bit vld, bit ack, bit clr);
    int c;
    if (r) begin
      m_halted = 0; m_in_resync = 0; m_streak = 0; m_streak_lane = 0;
      m_wait = 0; m_flane = 0; m_rc = 0;
      foreach (m_err[i]) m_err[i] = 0;
    end else if (m_halted) begin
      if (clr) begin m_halted = 0; m_streak = 0; m_wait = 0; end
    end else if (m_in_resync) begin
      if (ack) begin
        m_in_resync = 0; m_streak = 0;
        if (m_rc < 255) m_rc++;
      end else begin
        m_wait++;
        if (m_wait >= TO) begin m_in_resync = 0; m_halted = 1; end
      end
    end else if (vld) begin
      c = classify(vs);
      if (c == 0) m_streak = 0;
      else if (c < 0) m_halted = 1;
      else begin
        m_flane = c;
        if (m_err[c] < 65535) m_err[c]++;
        if (m_streak > 0 && c == m_streak_lane) m_streak++;
        else begin m_streak = 1; m_streak_lane = c; end
        if (m_streak >= P) begin m_in_resync = 1; m_wait = 0; end
      end
    end
  endtask

  function automatic logic [63:0] model_out();
    logic [2:0] ln;
    ln = m_in_resync ? 3'(1 << (m_streak_lane - 1)) : 3'b000;
    return {m_in_resync, ln, (m_in_resync | m_halted), m_halted, 2'(m_flane), 8'(m_rc),
            STATS ? 16'(m_err[1]) : 16'd0,
            STATS ? 16'(m_err[2]) : 16'd0,
            STATS ? 16'(m_err[3]) : 16'd0};
  endfunction

  function automatic logic [63:0] dut_out();
    return {Resync_req, Resync_lane, Core_stall, Fatal, Fault_lane, Resync_cnt,
            Err_cnt_A, Err_cnt_B, Err_cnt_C};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic drive(bit r, logic [2:0] vs, bit vld, bit ack, bit clr);
    rst_in = r; Voter_state = vs; Voter_valid = vld; Resync_ack = ack; Fault_clear = clr;
  endtask

  task automatic step(bit r, logic [2:0] vs, bit vld, bit ack, bit clr, string name);
    drive(r, vs, vld, ack, clr);
    @(posedge clk);
    model_step(r, vs, vld, ack, clr);
    #1;
    check(name, dut_out(), model_out());
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit r; bit [2:0] vs; bit vld, ack, clr;
    bit req; bit [2:0] lane; bit stall, fatal; bit [1:0] fl;
    int rc, ea, eb, ec;
  } vec_t;

  function automatic vec_t row(bit r, bit [2:0] vs, bit vld, bit ack, bit clr,
                               bit req, bit [2:0] lane, bit stall, bit fatal,
                               bit [1:0] fl, int rc, int ea, int eb, int ec);
    vec_t t;
    t.r = r; t.vs = vs; t.vld = vld; t.ack = ack; t.clr = clr;
    t.req = req; t.lane = lane; t.stall = stall; t.fatal = fatal; t.fl = fl;
    t.rc = rc; t.ea = ea; t.eb = eb; t.ec = ec;
    return t;
  endfunction

  function automatic logic [63:0] row_exp(vec_t t);
    return {t.req, t.lane, t.stall, t.fatal, t.fl, 8'(t.rc),
            STATS ? 16'(t.ea) : 16'd0, STATS ? 16'(t.eb) : 16'd0, STATS ? 16'(t.ec) : 16'd0};
  endfunction

  vec_t tbl[$];

  initial begin
    int reqs;
    int rc0;
    int cur_lane;
    logic [2:0] vs;
    int r;
    logic [2:0] nm[4];

    drive(1, 3'b111, 1, 0, 0);

    // reset
    tbl.push_back(row(1, 3'b111, 1, 0, 0,  0, 3'b000, 0, 0, 0, 0, 0, 0, 0));
    // transient on A (two samples), then clean; stray ack/clear in NORMAL ignored
    tbl.push_back(row(0, 3'b010, 1, 0, 0,  0, 3'b000, 0, 0, 1, 0, 1, 0, 0));
    tbl.push_back(row(0, 3'b010, 1, 0, 0,  0, 3'b000, 0, 0, 1, 0, 2, 0, 0));
    tbl.push_back(row(0, 3'b111, 1, 1, 0,  0, 3'b000, 0, 0, 1, 0, 2, 0, 0));
    tbl.push_back(row(0, 3'b111, 1, 0, 1,  0, 3'b000, 0, 0, 1, 0, 2, 0, 0));
    // persistent B: resync after 4th sample, ack after 3 request cycles
    tbl.push_back(row(0, 3'b001, 1, 0, 0,  0, 3'b000, 0, 0, 2, 0, 2, 1, 0));
    tbl.push_back(row(0, 3'b001, 1, 0, 0,  0, 3'b000, 0, 0, 2, 0, 2, 2, 0));
    tbl.push_back(row(0, 3'b001, 1, 0, 0,  0, 3'b000, 0, 0, 2, 0, 2, 3, 0));
    tbl.push_back(row(0, 3'b001, 1, 0, 0,  1, 3'b010, 1, 0, 2, 0, 2, 4, 0));
    tbl.push_back(row(0, 3'b001, 1, 0, 0,  1, 3'b010, 1, 0, 2, 0, 2, 4, 0));
    tbl.push_back(row(0, 3'b001, 1, 0, 0,  1, 3'b010, 1, 0, 2, 0, 2, 4, 0));
    tbl.push_back(row(0, 3'b001, 1, 1, 0,  0, 3'b000, 0, 0, 2, 1, 2, 4, 0));
    // persistent C, then timeout after TO request cycles
    tbl.push_back(row(0, 3'b100, 1, 0, 0,  0, 3'b000, 0, 0, 3, 1, 2, 4, 1));
    tbl.push_back(row(0, 3'b100, 1, 0, 0,  0, 3'b000, 0, 0, 3, 1, 2, 4, 2));
    tbl.push_back(row(0, 3'b100, 1, 0, 0,  0, 3'b000, 0, 0, 3, 1, 2, 4, 3));
    tbl.push_back(row(0, 3'b100, 1, 0, 0,  1, 3'b100, 1, 0, 3, 1, 2, 4, 4));
    for (int i = 0; i < TO - 1; i++)
      tbl.push_back(row(0, 3'b000, 1, 0, 0, 1, 3'b100, 1, 0, 3, 1, 2, 4, 4));
    tbl.push_back(row(0, 3'b111, 1, 0, 0,  0, 3'b000, 1, 1, 3, 1, 2, 4, 4));
    tbl.push_back(row(0, 3'b111, 1, 0, 0,  0, 3'b000, 1, 1, 3, 1, 2, 4, 4));
    tbl.push_back(row(0, 3'b111, 1, 0, 1,  0, 3'b000, 0, 0, 3, 1, 2, 4, 4));
    // no-majority codes
    tbl.push_back(row(0, 3'b000, 1, 0, 0,  0, 3'b000, 1, 1, 3, 1, 2, 4, 4));
    tbl.push_back(row(0, 3'b111, 1, 0, 1,  0, 3'b000, 0, 0, 3, 1, 2, 4, 4));
    tbl.push_back(row(0, 3'b011, 1, 0, 0,  0, 3'b000, 1, 1, 3, 1, 2, 4, 4));
    tbl.push_back(row(0, 3'b111, 1, 0, 1,  0, 3'b000, 0, 0, 3, 1, 2, 4, 4));
    // lane switch restarts the streak; an invalid sample holds
    tbl.push_back(row(0, 3'b100, 1, 0, 0,  0, 3'b000, 0, 0, 3, 1, 2, 4, 5));
    tbl.push_back(row(0, 3'b100, 1, 0, 0,  0, 3'b000, 0, 0, 3, 1, 2, 4, 6));
    tbl.push_back(row(0, 3'b010, 1, 0, 0,  0, 3'b000, 0, 0, 1, 1, 3, 4, 6));
    tbl.push_back(row(0, 3'b001, 0, 0, 0,  0, 3'b000, 0, 0, 1, 1, 3, 4, 6));
    tbl.push_back(row(0, 3'b010, 1, 0, 0,  0, 3'b000, 0, 0, 1, 1, 4, 4, 6));
    tbl.push_back(row(0, 3'b010, 1, 0, 0,  0, 3'b000, 0, 0, 1, 1, 5, 4, 6));
    tbl.push_back(row(0, 3'b010, 1, 0, 0,  1, 3'b001, 1, 0, 1, 1, 6, 4, 6));
    // reset mid-RESYNC discards a pending ack
    tbl.push_back(row(1, 3'b111, 1, 1, 1,  0, 3'b000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, 3'b111, 1, 0, 0,  0, 3'b000, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].vs, tbl[i].vld, tbl[i].ack, tbl[i].clr);
      @(posedge clk);
      model_step(tbl[i].r, tbl[i].vs, tbl[i].vld, tbl[i].ack, tbl[i].clr);
      #1;
      check($sformatf("vec%0d", i), dut_out(), row_exp(tbl[i]));
    end

    // ack in the first RESYNC cycle gives a one-cycle request
    reqs = 0;
    rc0  = m_rc;
    for (int i = 0; i < P; i++) begin
      step(0, 3'b001, 1, 0, 0, "pulse_fill");
      reqs += int'(Resync_req);
    end
    step(0, 3'b111, 1, 1, 0, "pulse_ack");
    reqs += int'(Resync_req);
    check("pulse_width", 64'(reqs), 64'd1);
    check("pulse_cnt", 64'(Resync_cnt), 64'(rc0 + 1));

    // ack arriving on the timeout cycle wins
    for (int i = 0; i < P; i++) step(0, 3'b010, 1, 0, 0, "race_fill");
    for (int i = 0; i < TO - 1; i++) step(0, 3'b111, 1, 0, 0, "race_wait");
    step(0, 3'b111, 1, 1, 0, "race_ack");
    check("race_fatal", 64'(Fatal), 64'd0);
    check("race_cnt", 64'(Resync_cnt), 64'(rc0 + 2));

    // reset mid-HALT discards a pending clear
    step(0, 3'b101, 1, 0, 0, "halt_enter");
    check("halt_fatal", 64'(Fatal), 64'd1);
    step(1, 3'b111, 1, 0, 1, "halt_reset");
    check("halt_reset_zero", dut_out(), 64'd0);

    // randomized traffic
    nm[0] = 3'b000; nm[1] = 3'b011; nm[2] = 3'b101; nm[3] = 3'b110;
    cur_lane = 1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) == 0) cur_lane = int'($urandom_range(1, 3));
      r = int'($urandom_range(0, 99));
      if (r < 50)      vs = 3'b111;
      else if (r < 90) vs = (cur_lane == 1) ? 3'b010 : (cur_lane == 2) ? 3'b001 : 3'b100;
      else if (r < 94) vs = nm[$urandom_range(0, 3)];
      else             vs = 3'($urandom_range(0, 7));
      step(($urandom_range(0, 399) == 0), vs, ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 6) == 0), ($urandom_range(0, 3) == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
